hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit: tracks in-flight register writers in an internal DEPTH-stage shadow pipeline (EX..WB).
//  Per operand it produces forward-source selects and stall/bubble control.
//  Result latency is per instruction, so loads, CP0 reads and SC need no per-stage special cases.
//  Sits beside the ID/EX boundary; the ID-use selects drive the branch/movn compare muxes and the EX-use selects
//  drive the EX operand muxes.
// PARAMETERS
//  RW     5   register index width (2**RW architectural regs, reg 0 never tracked)
//  DEPTH  4   shadow stages after ID: 1=EX, 2=MEM1, 3=MEM2, DEPTH=WB
//  FLUSH  2   stage raising exception/eret; flush kills ID and stages 1..FLUSH-1
//  CW     32  stall-cycle counter width
//  SW     clog2(DEPTH+1) select width; value 0 = regfile, s = shadow stage s
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous reset, active-low
//  hold       in   1      cache stall: freeze whole pipeline this cycle
//  flush      in   1      exception/eret flush from stage FLUSH
//  ID_valid   in   1      instruction in ID is real (not a bubble)
//  ID_RS      in   RW     source register A
//  ID_RT      in   RW     source register B
//  ID_RSUse   in   1      A is read
//  ID_RTUse   in   1      B is read
//  ID_Early   in   1      operands consumed in ID (branch, movn/movz), else in EX
//  ID_RFWr    in   1      ID instr writes regfile
//  ID_RD      in   RW     destination register
//  ID_Lat     in   SW     first stage whose register holds the result (ALU=2, load/CP0/SC=3)
//  ID_MDUse   in   1      ID instr reads HI/LO or starts mul/div
//  md_busy    in   1      mul/div unit busy
//  PCWr       out  1      PC/PF/IF/ID registers advance
//  IF_IDWr    out  1      equals PCWr
//  ID_EXWr    out  1      ID/EX and later registers advance (= ~hold)
//  ID_Bubble  out  1      load NOP into EX instead of ID instr
//  ID_FwdRS   out  SW     early-use select for A (comb)
//  ID_FwdRT   out  SW     early-use select for B (comb)
//  EX_FwdRS   out  SW     EX-use select for A (registered)
//  EX_FwdRT   out  SW     EX-use select for B (registered)
//  isStall    out  1      ~PCWr
//  stall_cnt  out  CW     saturating count of data-hazard stall cycles
// BEHAVIOUR
//  - Shadow entry e[s], s=1..DEPTH: {v, rd, lat}. v set only if RFWr and rd!=0.
//  - Operand match: youngest (lowest s) entry with v && rd==src; src 0 or Use=0 -> no match, select 0.
//  - Early use: ok iff s>=lat; ID_FwdRx=s. EX use: ok iff s+1>=lat; next EX select = (s+1>DEPTH)?0:s+1.
//  - Stall conditions:
//    - dstall = ID_valid & any matched operand not ok.
//    - mstall = ID_valid & ID_MDUse & md_busy.
//  - Priority each cycle: flush > hold > stall > normal.
//    - flush: e[1..FLUSH-1].v<=0, EX_Fwd*<=0, older entries shift normally. PCWr=1, ID_Bubble=1.
//      hold is ignored for those stages.
//    - hold: all state frozen, PCWr=0, ID_EXWr=0, ID_Bubble=0. Selects recomputed from frozen state.
//    - stall (dstall|mstall): shift, e[1]<=bubble, EX_Fwd*<=0, PCWr=0, ID_Bubble=1.
//    - normal: shift, e[1]<={ID_valid&ID_RFWr&ID_RD!=0, ID_RD, ID_Lat}, EX_Fwd* <= computed EX selects.
//  - Shift drops e[DEPTH]; WB writes the regfile that cycle, so reads afterwards use select 0.
//  - stall_cnt += 1 on each cycle with dstall & ~hold & ~flush, saturating at all-ones.
//  - Reset (rst=0, async): all v=0, EX_Fwd*=0, stall_cnt=0.
//    - Comb outputs then: PCWr=1, IF_IDWr=1, ID_EXWr=~hold, ID_Bubble=0, ID_Fwd*=0, isStall=0.
//  - ID_Lat=0 or 1 is treated as 1 (result usable from the EX output); ID_Lat>DEPTH is treated as DEPTH.
// TESTING
//  - ALU chain: add r3 then sub r4,r3 back to back -> no stall, EX_FwdRS=2 next cycle.
//    With one unrelated instr between them: EX_FwdRS=3.
//  - Load-use: lw r5(lat=3) then add r6,r5 -> one stall cycle (ID_Bubble=1, PCWr=0), then EX_FwdRS=3.
//    stall_cnt increments by 1.
//  - Branch on ALU result: add r7 then beq r7 (Early) -> 1 stall cycle, then ID_FwdRS=2.
//    Branch on load r7 instead -> 2 stall cycles, then ID_FwdRS=3.
//  - hold for 5 cycles during load-use stall -> all outputs frozen, stall_cnt unchanged, then resumes identically.
//  - flush while lw r5 in EX and add r5 in ID -> e[1] cleared, no further stall, EX_FwdRS=0.
//    r0 as destination never causes stall or forwarding.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer tracking, forward selects and stall control beside ID/EX
//   clk, rst (async, active-low)
//   hold, flush, ID_* instruction info, md_busy -> inputs
//   PCWr, IF_IDWr, ID_EXWr, ID_Bubble, ID_FwdRS/RT (comb), EX_FwdRS/RT (reg), isStall, stall_cnt -> outputs
module hazard_scoreboard #(
  parameter int RW    = 5,
  parameter int DEPTH = 4,
  parameter int FLUSH = 2,
  parameter int CW    = 32,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          ID_valid,
  input  logic [RW-1:0] ID_RS,
  input  logic [RW-1:0] ID_RT,
  input  logic          ID_RSUse,
  input  logic          ID_RTUse,
  input  logic          ID_Early,
  input  logic          ID_RFWr,
  input  logic [RW-1:0] ID_RD,
  input  logic [SW-1:0] ID_Lat,
  input  logic          ID_MDUse,
  input  logic          md_busy,
  output logic          PCWr,
  output logic          IF_IDWr,
  output logic          ID_EXWr,
  output logic          ID_Bubble,
  output logic [SW-1:0] ID_FwdRS,
  output logic [SW-1:0] ID_FwdRT,
  output logic [SW-1:0] EX_FwdRS,
  output logic [SW-1:0] EX_FwdRT,
  output logic          isStall,
  output logic [CW-1:0] stall_cnt
);
  logic [DEPTH:1]             v_q, v_d;
  logic [DEPTH:1][RW-1:0]     rd_q, rd_d;
  logic [DEPTH:1][SW-1:0]     lat_q, lat_d;
  logic [1:0][SW-1:0]         ex_q, ex_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [1:0][RW-1:0]         src;
  logic [1:0]                 uses;
  logic [1:0][SW-1:0]         hit, hl, ex_sel;
  logic [1:0]                 bad;
  logic [SW-1:0]              lat_in;
  logic                       dstall, mstall, stall;

  assign src    = {ID_RT, ID_RS};
  assign uses   = {ID_RTUse, ID_RSUse};
  assign lat_in = (ID_Lat == '0) ? SW'(1) : (ID_Lat > SW'(DEPTH)) ? SW'(DEPTH) : ID_Lat;

  // scanning oldest to youngest lets the youngest matching writer win
  always_comb begin
    hit    = '0;
    hl     = '0;
    bad    = '0;
    ex_sel = '0;
    for (int o = 0; o < 2; o++) begin
      for (int s = DEPTH; s >= 1; s--)
        if (uses[o] && src[o] != '0 && v_q[s] && rd_q[s] == src[o]) begin
          hit[o] = SW'(s);
          hl[o]  = lat_q[s];
        end
      // EX-use reads one stage later, so the producer has advanced by one
      bad[o]    = hit[o] != '0 && ({1'b0, hit[o]} + {{SW{1'b0}}, ~ID_Early} < {1'b0, hl[o]});
      ex_sel[o] = (hit[o] == '0 || hit[o] == SW'(DEPTH)) ? '0 : hit[o] + 1'b1;
    end
  end

  assign dstall = ID_valid & |bad;
  assign mstall = ID_valid & ID_MDUse & md_busy;
  assign stall  = dstall | mstall;

  always_comb begin
    v_d   = v_q;
    rd_d  = rd_q;
    lat_d = lat_q;
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush || !hold) begin
      // after the shift, stages 2..FLUSH hold what was in 1..FLUSH-1: those instructions are killed
      for (int s = DEPTH; s >= 2; s--) begin
        v_d[s]   = v_q[s-1] && !(flush && s <= FLUSH);
        rd_d[s]  = rd_q[s-1];
        lat_d[s] = lat_q[s-1];
      end
      v_d[1]   = !flush && !stall && ID_valid && ID_RFWr && ID_RD != '0;
      rd_d[1]  = ID_RD;
      lat_d[1] = lat_in;
      ex_d     = (flush || stall) ? '0 : ex_sel;
    end
    if (dstall && !hold && !flush && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v_q   <= '0;
      rd_q  <= '0;
      lat_q <= '0;
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      rd_q  <= rd_d;
      lat_q <= lat_d;
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end

  assign PCWr      = flush | (~hold & ~stall);
  assign IF_IDWr   = PCWr;
  assign ID_EXWr   = ~hold;
  assign ID_Bubble = flush | (~hold & stall);
  assign isStall   = ~PCWr;
  assign ID_FwdRS  = hit[0];
  assign ID_FwdRT  = hit[1];
  assign EX_FwdRS  = ex_q[0];
  assign EX_FwdRT  = ex_q[1];
  assign stall_cnt = cnt_q;
endmodule
